// File: rtl/mod_n_updown_counter.sv
// Runtime-programmable modulo up/down counter.
// Counts 0..term_val in either direction, with sync clear, parallel load,
// count enable and a one-shot mode that halts after the first wrap.
// tc is combinational so stages can be cascaded without ripple latency.
module mod_n_updown_counter #(
  parameter int                 WIDTH    = 4,
  parameter logic [WIDTH-1:0]   TERM_RST = WIDTH'(4'd13)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             done
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic             wrap_r;
  logic             wrap_nxt_s;
  logic             done_r;
  logic             done_nxt_s;
  logic             at_wrap_s;
  logic             count_ok_s;
  logic             tc_s;

  // Wrap point detection; an out-of-range q always counts as a wrap point.
  always_comb begin
    at_wrap_s = 1'b0;
    if (up_dn) begin
      at_wrap_s = (q_r >= term_val);
    end else begin
      at_wrap_s = (q_r == {WIDTH{1'b0}}) | (q_r > term_val);
    end
  end

  assign count_ok_s = en & (state_r == ST_RUN);

  // State register: RUN/HALT, async reset to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: clr/load always return to RUN; a one-shot wrap halts.
  always_comb begin
    state_nxt_s = state_r;
    if (clr || load) begin
      state_nxt_s = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (tc_s && oneshot) begin
            state_nxt_s = ST_HALT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_HALT: begin
          state_nxt_s = ST_HALT;
        end
        default: begin
          state_nxt_s = ST_RUN;
        end
      endcase
    end
  end

  // Output decode: terminal count, and the done value to register.
  always_comb begin
    tc_s       = 1'b0;
    done_nxt_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        tc_s = count_ok_s & at_wrap_s;
      end
      ST_HALT: begin
        tc_s = 1'b0;
      end
      default: begin
        tc_s = 1'b0;
      end
    endcase
    done_nxt_s = (state_nxt_s == ST_HALT);
  end

  // Next count and wrap pulse with clr > load > count priority.
  always_comb begin
    q_nxt_s    = q_r;
    wrap_nxt_s = 1'b0;
    if (clr) begin
      q_nxt_s    = {WIDTH{1'b0}};
      wrap_nxt_s = 1'b0;
    end else if (load) begin
      q_nxt_s    = load_val;
      wrap_nxt_s = 1'b0;
    end else if (count_ok_s) begin
      wrap_nxt_s = tc_s;
      if (at_wrap_s) begin
        if (up_dn) begin
          q_nxt_s = {WIDTH{1'b0}};
        end else begin
          q_nxt_s = term_val;
        end
      end else begin
        if (up_dn) begin
          q_nxt_s = q_r + WIDTH'(1'b1);
        end else begin
          q_nxt_s = q_r - WIDTH'(1'b1);
        end
      end
    end else begin
      q_nxt_s    = q_r;
      wrap_nxt_s = 1'b0;
    end
  end

  // Datapath registers: count, wrap pulse and done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r    <= {WIDTH{1'b0}};
      wrap_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      q_r    <= q_nxt_s;
      wrap_r <= wrap_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  assign q    = q_r;
  assign tc   = tc_s;
  assign wrap = wrap_r;
  assign done = done_r;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed bench for mod_n_updown_counter: up/down counting, load/clear
// priority, one-shot halt, async reset, term_val=0 and a two-stage BCD cascade.
module tb_mod_n_updown_counter;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       up_dn;
  logic       oneshot;
  logic [3:0] term_val;
  logic [3:0] q;
  logic       tc;
  logic       wrap;
  logic       done;

  // second stage of the cascade, enabled by the first stage's tc
  logic       load2;
  logic [3:0] load_val2;
  logic       up_dn2;
  logic       oneshot2;
  logic [3:0] term_val2;
  logic [3:0] q2;
  logic       tc2;
  logic       wrap2;
  logic       done2;

  int checks;
  int failures;

  mod_n_updown_counter #(.WIDTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .oneshot(oneshot), .term_val(term_val),
    .q(q), .tc(tc), .wrap(wrap), .done(done)
  );

  mod_n_updown_counter #(.WIDTH(4)) u_stage2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load2), .load_val(load_val2),
    .en(tc), .up_dn(up_dn2), .oneshot(oneshot2), .term_val(term_val2),
    .q(q2), .tc(tc2), .wrap(wrap2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] e;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    load      = 1'b0;
    load_val  = 4'd0;
    en        = 1'b0;
    up_dn     = 1'b1;
    oneshot   = 1'b0;
    term_val  = 4'd13;
    load2     = 1'b0;
    load_val2 = 4'd0;
    up_dn2    = 1'b1;
    oneshot2  = 1'b0;
    term_val2 = 4'd9;

    // reset state
    #12;
    check("rst_q", {4'd0, q}, 8'd0);
    check("rst_wrap", {7'd0, wrap}, 8'd0);
    check("rst_done", {7'd0, done}, 8'd0);
    rst_n = 1'b1;
    tick();

    // 1: term=13 up, 30 clocks
    en = 1'b1;
    up_dn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      settle();
      check("t1_q", {4'd0, q}, 8'(i % 14));
      check("t1_tc", {7'd0, tc}, ((i % 14) == 13) ? 8'd1 : 8'd0);
      tick();
      check("t1_wrap", {7'd0, wrap}, ((i % 14) == 13) ? 8'd1 : 8'd0);
    end

    // 2: term=9 down from 0
    clr = 1'b1;
    tick();
    clr = 1'b0;
    term_val = 4'd9;
    up_dn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      settle();
      e = 4'((10 - (i % 10)) % 10);
      check("t2_q", {4'd0, q}, {4'd0, e});
      check("t2_tc", {7'd0, tc}, (e == 4'd0) ? 8'd1 : 8'd0);
      tick();
    end
    load = 1'b1;
    load_val = 4'd12;
    tick();
    load = 1'b0;
    settle();
    check("t2_load_q", {4'd0, q}, 8'd12);
    check("t2_oor_tc", {7'd0, tc}, 8'd1);
    tick();
    check("t2_oor_down_q", {4'd0, q}, 8'd9);

    // 3: term=5 up, load 7, then clr+load together
    term_val = 4'd5;
    up_dn = 1'b1;
    load = 1'b1;
    load_val = 4'd7;
    tick();
    load = 1'b0;
    settle();
    check("t3_load_q", {4'd0, q}, 8'd7);
    check("t3_oor_tc", {7'd0, tc}, 8'd1);
    tick();
    check("t3_wrap_q", {4'd0, q}, 8'd0);
    check("t3_wrap", {7'd0, wrap}, 8'd1);
    tick();
    check("t3_q1", {4'd0, q}, 8'd1);
    clr = 1'b1;
    load = 1'b1;
    load_val = 4'd3;
    tick();
    clr = 1'b0;
    load = 1'b0;
    check("t3_clr_over_load", {4'd0, q}, 8'd0);

    // 4: one-shot, term=3 up
    term_val = 4'd3;
    oneshot = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t4_q", {4'd0, q}, 8'(i));
      check("t4_tc", {7'd0, tc}, (i == 3) ? 8'd1 : 8'd0);
      tick();
    end
    check("t4_halt_q", {4'd0, q}, 8'd0);
    check("t4_done", {7'd0, done}, 8'd1);
    check("t4_wrap", {7'd0, wrap}, 8'd1);
    settle();
    check("t4_halt_tc", {7'd0, tc}, 8'd0);
    tick();
    check("t4_hold_q", {4'd0, q}, 8'd0);
    check("t4_hold_done", {7'd0, done}, 8'd1);
    check("t4_hold_wrap", {7'd0, wrap}, 8'd0);
    load = 1'b1;
    load_val = 4'd2;
    tick();
    load = 1'b0;
    check("t4_reload_q", {4'd0, q}, 8'd2);
    check("t4_reload_done", {7'd0, done}, 8'd0);
    tick();
    check("t4_count_q", {4'd0, q}, 8'd3);

    // 6b: one-shot down halt at q=3, then async reset mid-HALT
    clr = 1'b1;
    tick();
    clr = 1'b0;
    up_dn = 1'b0;
    tick();
    check("t6_halt_q", {4'd0, q}, 8'd3);
    check("t6_halt_done", {7'd0, done}, 8'd1);
    check("t6_halt_wrap", {7'd0, wrap}, 8'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_async_q", {4'd0, q}, 8'd0);
    check("t6_async_done", {7'd0, done}, 8'd0);
    check("t6_async_wrap", {7'd0, wrap}, 8'd0);
    #4;
    rst_n = 1'b1;
    oneshot = 1'b0;
    tick();

    // 5: BCD cascade, 250 clocks
    clr = 1'b1;
    tick();
    clr = 1'b0;
    term_val = 4'd9;
    up_dn = 1'b1;
    en = 1'b1;
    for (int n = 0; n < 250; n++) begin
      settle();
      check("t5_bcd", {q2, q}, {4'((n % 100) / 10), 4'(n % 10)});
      tick();
    end
    check("t5_final", {q2, q}, 8'h50);

    // 6a: term=0 divides by one, both directions
    clr = 1'b1;
    tick();
    clr = 1'b0;
    term_val = 4'd0;
    for (int i = 0; i < 6; i++) begin
      up_dn = (i < 3) ? 1'b1 : 1'b0;
      settle();
      check("t6_t0_q", {4'd0, q}, 8'd0);
      check("t6_t0_tc", {7'd0, tc}, 8'd1);
      tick();
    end
    en = 1'b0;
    settle();
    check("t6_t0_noen_tc", {7'd0, tc}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
